// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: operand/result structs and ID width helper for mult_arbiter
`include "constants.sv"
package mult_arb_pkg;
  localparam int IN_W = `MULT_IN_SIZE;
  localparam int OUT_W = `MULT_OUT_SIZE;
  localparam int ID_MAX_W = 4;
  typedef struct packed {
    logic signed [IN_W-1:0] re_x, im_x, re_y, im_y;
  } operand_t;
  typedef struct packed {
    logic signed [OUT_W-1:0] re_z, im_z;
    logic [ID_MAX_W-1:0] id;
  } result_t;
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/constants.sv
// constants: shared operand/product widths for the complex multiplier datapath
`ifndef CONSTANTS_SV
`define CONSTANTS_SV
`define MULT_IN_SIZE 16
`define MULT_OUT_SIZE 33
`endif

// File: rtl/mult.sv
// mult: combinational complex multiplier, z = x * y
`include "constants.sv"
module mult (
  input  logic signed [`MULT_IN_SIZE-1:0]  re_x,
  input  logic signed [`MULT_IN_SIZE-1:0]  im_x,
  input  logic signed [`MULT_IN_SIZE-1:0]  re_y,
  input  logic signed [`MULT_IN_SIZE-1:0]  im_y,
  output logic signed [`MULT_OUT_SIZE-1:0] re_z,
  output logic signed [`MULT_OUT_SIZE-1:0] im_z
);
  logic signed [`MULT_OUT_SIZE-1:0] a, b, c, d;
  assign a = `MULT_OUT_SIZE'(re_x);
  assign b = `MULT_OUT_SIZE'(im_x);
  assign c = `MULT_OUT_SIZE'(re_y);
  assign d = `MULT_OUT_SIZE'(im_y);
  assign re_z = a * c - b * d;
  assign im_z = a * d + b * c;
endmodule

// File: rtl/mult_arb_grant.sv
// mult_arb_grant: one-hot grant selector; round-robin with rr_ptr when MULT_ARB_RR_EN is defined,
// otherwise fixed priority (lowest index wins)
module mult_arb_grant
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = id_w(NUM_REQ)
) (
`ifdef MULT_ARB_RR_EN
  input  logic               clk,
  input  logic               reset,
`endif
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] ready_o,
  output logic [ID_W-1:0]    gnt_o,
  output logic               any_o
);
  assign any_o = |valid_i;
  assign ready_o = (adv_i && any_o) ? NUM_REQ'(1) << gnt_o : '0;
`ifdef MULT_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr_q;
  logic [NUM_REQ-1:0] rot;
  // rotate so bit 0 is the requester at rr_ptr; the lowest set bit is the next in turn
  assign rot = NUM_REQ'({valid_i, valid_i} >> rr_ptr_q);
  always_comb begin
    gnt_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (rot[k]) gnt_o = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
  end
  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else if (adv_i && any_o) rr_ptr_q <= gnt_o == ID_W'(NUM_REQ - 1) ? '0 : gnt_o + ID_W'(1);
  end
`else
  always_comb begin
    gnt_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (valid_i[k]) gnt_o = ID_W'(k);
  end
`endif
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one complex multiplier among NUM_REQ requesters via a two-stage pipeline;
// MULT_ARB_RR_EN selects round-robin arbitration instead of fixed priority
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = id_w(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic signed [IN_W-1:0]  req_re_x [NUM_REQ],
  input  logic signed [IN_W-1:0]  req_im_x [NUM_REQ],
  input  logic signed [IN_W-1:0]  req_re_y [NUM_REQ],
  input  logic signed [IN_W-1:0]  req_im_y [NUM_REQ],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_re_z,
  output logic signed [OUT_W-1:0] out_im_z,
  output logic [ID_W-1:0]         out_id
);
  logic adv1, adv2, any;
  logic [ID_W-1:0] gnt, s1_id_q, id_q;
  logic s1_valid_q, out_valid_q;
  operand_t s1_op_q;
  logic signed [OUT_W-1:0] mre, mim, re_z_q, im_z_q;
  assign adv2 = !out_valid_q || out_ready;
  assign adv1 = !s1_valid_q || adv2;
  mult_arb_grant #(.NUM_REQ(NUM_REQ)) u_grant (
`ifdef MULT_ARB_RR_EN
    .clk(clk),
    .reset(reset),
`endif
    .valid_i(req_valid),
    .adv_i(adv1),
    .ready_o(req_ready),
    .gnt_o(gnt),
    .any_o(any)
  );
  mult u_mult (
    .re_x(s1_op_q.re_x),
    .im_x(s1_op_q.im_x),
    .re_y(s1_op_q.re_y),
    .im_y(s1_op_q.im_y),
    .re_z(mre),
    .im_z(mim)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q <= '0;
      s1_id_q <= '0;
      out_valid_q <= 1'b0;
      re_z_q <= '0;
      im_z_q <= '0;
      id_q <= '0;
    end else begin
      if (adv1) s1_valid_q <= any;
      if (adv1 && any) begin
        s1_op_q <= '{re_x: req_re_x[gnt], im_x: req_im_x[gnt], re_y: req_re_y[gnt], im_y: req_im_y[gnt]};
        s1_id_q <= gnt;
      end
      if (adv2) begin
        out_valid_q <= s1_valid_q;
        re_z_q <= mre;
        im_z_q <= mim;
        id_q <= s1_id_q;
      end
    end
  end
  assign out_valid = out_valid_q;
  assign out_re_z = re_z_q;
  assign out_im_z = im_z_q;
  assign out_id = id_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: vector table plus scoreboard checks for mult_arbiter
module tb_mult_arbiter;
  import mult_arb_pkg::*;
  localparam int N = 4;
`ifdef MULT_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {
    int r;
    int xr, xi, yr, yi;
    longint er, ei;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic signed [IN_W-1:0] rx [N], ix [N], ry [N], iy [N];
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [OUT_W-1:0] out_re_z, out_im_z;
  logic [1:0] out_id;
  int checks = 0;
  int failures = 0;
  result_t sbq [$];
  vec_t tv [6];
  result_t hold;
  always #5 clk = ~clk;
  mult_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_re_x(rx), .req_im_x(ix), .req_re_y(ry), .req_im_y(iy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re_z(out_re_z), .out_im_z(out_im_z), .out_id(out_id)
  );
  function automatic result_t model(input int i);
    longint a = rx[i], b = ix[i], c = ry[i], d = iy[i];
    result_t r;
    r.re_z = OUT_W'(a * c - b * d);
    r.im_z = OUT_W'(a * d + b * c);
    r.id = 4'(i);
    return r;
  endfunction
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_reset();
    @(posedge clk) #1;
    reset = 1'b1;
    req_valid = '0;
    @(posedge clk) #1;
    reset = 1'b0;
  endtask
  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      rx[i] = IN_W'($urandom);
      ix[i] = IN_W'($urandom);
      ry[i] = IN_W'($urandom);
      iy[i] = IN_W'($urandom);
    end
  endtask
  always @(negedge clk) begin
    result_t e;
    if (reset) sbq.delete();
    else begin
      chk("ready_legal", longint'((req_ready & ~req_valid) == '0 && $onehot0(req_ready)), 1);
      if (out_valid && out_ready) begin
        chk("sb_nonempty", longint'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("sb_re", out_re_z, e.re_z);
          chk("sb_im", out_im_z, e.im_z);
          chk("sb_id", out_id, e.id);
        end
      end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_ready[i]) sbq.push_back(model(i));
    end
  end
  initial begin
    for (int i = 0; i < N; i++) begin
      rx[i] = '0; ix[i] = '0; ry[i] = '0; iy[i] = '0;
    end
    tv[0] = '{0, 1, 2, 3, 4, -5, 10};
    tv[1] = '{2, -3, 5, 7, -2, -11, 41};
    tv[2] = '{3, -32768, -32768, -32768, -32768, 0, 64'd2147483648};
    tv[3] = '{1, -32768, 32767, -32768, -32768, 2147450880, 32768};
    tv[4] = '{1, 32767, 0, 32767, 32767, 1073676289, 1073676289};
    tv[5] = '{0, -32768, 0, 32767, -32768, -1073709056, 1073741824};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_re", out_re_z, 0);
    chk("rst_im", out_im_z, 0);
    chk("rst_id", out_id, 0);
    @(posedge clk) #1;
    reset = 1'b0;
    for (int t = 0; t < 6; t++) begin
      int r;
      r = tv[t].r;
      @(posedge clk) #1;
      rx[r] = IN_W'(tv[t].xr);
      ix[r] = IN_W'(tv[t].xi);
      ry[r] = IN_W'(tv[t].yr);
      iy[r] = IN_W'(tv[t].yi);
      req_valid[r] = 1'b1;
      @(negedge clk);
      chk("vec_ready", req_ready, 1 << r);
      @(posedge clk) #1;
      req_valid[r] = 1'b0;
      @(negedge clk);
      chk("vec_latency", out_valid, 0);
      @(negedge clk);
      chk("vec_valid", out_valid, 1);
      chk("vec_re", out_re_z, tv[t].er);
      chk("vec_im", out_im_z, tv[t].ei);
      chk("vec_id", out_id, r);
    end
    do_reset();
    rand_ops();
    out_ready = 1'b1;
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("stream_ready", req_ready, 1 << (RR ? k % N : 0));
      if (k >= 2) begin
        chk("stream_valid", out_valid, 1);
        chk("stream_id", out_id, RR ? (k - 2) % N : 0);
      end
    end
    @(posedge clk) #1;
    req_valid = '0;
    repeat (3) @(negedge clk);
    do_reset();
    rand_ops();
    out_ready = 1'b0;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("bp_ready1", req_ready, 4'b0010);
    @(posedge clk) #1;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("bp_ready2", req_ready, 4'b0100);
    @(posedge clk) #1;
    req_valid = 4'b0001;
    hold = model(1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready_blocked", req_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_id", out_id, 1);
      chk("bp_hold_re", out_re_z, hold.re_z);
      chk("bp_hold_im", out_im_z, hold.im_z);
    end
    @(posedge clk) #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_ready", req_ready, 4'b0001);
    chk("bp_rel_id1", out_id, 1);
    @(posedge clk) #1;
    req_valid = '0;
    @(negedge clk);
    chk("bp_rel_valid2", out_valid, 1);
    chk("bp_rel_id2", out_id, 2);
    @(negedge clk);
    chk("bp_rel_valid0", out_valid, 1);
    chk("bp_rel_id0", out_id, 0);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);
    @(posedge clk) #1;
    out_ready = 1'b0;
    req_valid = 4'b1000;
    @(posedge clk) #1;
    req_valid = 4'b0100;
    @(posedge clk) #1;
    req_valid = '0;
    @(negedge clk);
    chk("mid_full", out_valid, 1);
    @(posedge clk) #1;
    reset = 1'b1;
    @(posedge clk) #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    repeat (4) begin
      @(negedge clk);
      chk("mid_no_stale", out_valid, 0);
    end
    @(posedge clk) #1;
    req_valid = '1;
    @(negedge clk);
    chk("mid_first_grant", req_ready, 4'b0001);
    @(posedge clk) #1;
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
